// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_ctrl
// Brief    : Instruction memory with req/valid fetch handshake, wait states,
//            post-reset clear, fault reporting and a write-only program port.
//            Optional parity storage enabled by defining INSTR_MEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [31:0]     fetch_addr,
  output logic            fetch_ready,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic            fetch_fault,
  input  logic            prog_we,
  input  logic [31:0]     prog_addr,
  input  logic [XLEN-1:0] prog_data,
  input  logic            prog_inj_err,
  output logic            prog_busy,
  output logic            parity_err
);

  localparam logic [31:0]     c_BYTE_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]      c_WAIT_LAST  = 4'(WAIT_STATES - 1);
  localparam logic [AW-1:0]   c_CLR_LAST   = AW'(DEPTH - 1);
  localparam logic [XLEN-1:0] c_NOP        = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_cnt;
  logic [3:0]      r_wait_cnt;
  logic [31:0]     r_addr;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_accept;
  logic            w_enter_resp;
  logic [31:0]     w_rd_addr;
  logic            w_rd_fault;
  logic [AW-1:0]   w_rd_idx;
  logic            w_prog_ok;
  logic [AW-1:0]   w_prog_idx;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    fetch_ready = 1'b0;
    prog_busy   = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      S_CLEAR: begin
        prog_busy = 1'b1;
        if (r_clr_cnt == c_CLR_LAST) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_req) w_state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        instr_valid = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign w_accept     = fetch_ready & fetch_req;
  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // With zero wait states the read edge is the accept edge, so use the live address.
  assign w_rd_addr  = (r_state == S_IDLE) ? fetch_addr : r_addr;
  assign w_rd_fault = (w_rd_addr[1:0] != 2'b00) || (w_rd_addr >= c_BYTE_LIMIT);
  assign w_rd_idx   = w_rd_addr[AW+1:2];

  assign w_prog_ok  = prog_we && (r_state != S_CLEAR) &&
                      (prog_addr[1:0] == 2'b00) && (prog_addr < c_BYTE_LIMIT);
  assign w_prog_idx = prog_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt  <= '0;
      r_wait_cnt <= '0;
      r_addr     <= '0;
    end else begin
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + AW'(1);
      if (w_accept) begin
        r_addr     <= fetch_addr;
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) r_mem[r_clr_cnt]  <= '0;
      else if (w_prog_ok)     r_mem[w_prog_idx] <= prog_data;
    end
  end

  // Array read uses the pre-edge contents, giving read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= '0;
      fetch_fault <= 1'b0;
    end else if (w_enter_resp) begin
      if (w_rd_fault) begin
        instr       <= c_NOP;
        fetch_fault <= 1'b1;
      end else begin
        instr       <= r_mem[w_rd_idx];
        fetch_fault <= 1'b0;
      end
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) r_par[r_clr_cnt]  <= 1'b0;
      else if (w_prog_ok)     r_par[w_prog_idx] <= (^prog_data) ^ prog_inj_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             parity_err <= 1'b0;
    else if (w_enter_resp) parity_err <= !w_rd_fault && ((^r_mem[w_rd_idx]) != r_par[w_rd_idx]);
  end
`else
  logic w_unused_inj;
  assign w_unused_inj = prog_inj_err;
  assign parity_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_ctrl
// Brief    : Directed bench for instr_mem_ctrl with a cycle-numbered
//            reference model and a per-cycle output compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

  localparam int DEPTH = 64;
  localparam int WS    = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        prog_inj_err = 1'b0;
  logic        prog_busy;
  logic        parity_err;

  int n_vec = 0;
  int n_bad = 0;

  instr_mem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr), .fetch_fault(fetch_fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_inj_err(prog_inj_err), .prog_busy(prog_busy), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything is expressed as cycle numbers.
  int          cyc = 0;
  int          clear_end = 0;
  int          ready_at = 0;
  int          read_cyc = -1;
  int          resp_cyc = -1;
  bit          started = 0;
  logic [31:0] rd_addr = '0;
  logic [31:0] m_mem [DEPTH];
  bit          m_inj [DEPTH];
  logic [31:0] e_instr = '0;
  bit          e_fault = 0;
  bit          e_par = 0;

  always @(posedge clk) begin
    if (reset) begin
      started   = 1;
      clear_end = cyc + 1 + DEPTH;
      ready_at  = clear_end;
      read_cyc  = -1;
      resp_cyc  = -1;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_inj[i] = 0;
      end
    end else begin
      if (fetch_req && cyc >= ready_at) begin
        rd_addr  = fetch_addr;
        read_cyc = cyc + WS;
        ready_at = cyc + WS + 2;
      end
      if (read_cyc == cyc) begin
        resp_cyc = cyc + 1;
        if (rd_addr[1:0] != 2'b00 || rd_addr >= DEPTH * 4) begin
          e_instr = NOP;
          e_fault = 1;
          e_par   = 0;
        end else begin
          e_instr = m_mem[rd_addr / 4];
          e_fault = 0;
`ifdef INSTR_MEM_PARITY_EN
          e_par   = m_inj[rd_addr / 4];
`else
          e_par   = 0;
`endif
        end
      end
      if (prog_we && cyc >= clear_end && prog_addr[1:0] == 2'b00 && prog_addr < DEPTH * 4) begin
        m_mem[prog_addr / 4] = prog_data;
        m_inj[prog_addr / 4] = prog_inj_err;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, cyc >= ready_at});
      chk("prog_busy",   {31'b0, prog_busy},   {31'b0, cyc < clear_end});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, cyc == resp_cyc});
      if (cyc == resp_cyc) begin
        chk("instr",       instr, e_instr);
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, e_fault});
        chk("parity_err",  {31'b0, parity_err},  {31'b0, e_par});
      end
    end
  end

  task automatic prog(input logic [31:0] a, input logic [31:0] d, input bit inj);
    prog_we = 1'b1; prog_addr = a; prog_data = d; prog_inj_err = inj;
    @(negedge clk);
    prog_we = 1'b0; prog_inj_err = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_i, input bit exp_f,
                       input bit exp_p, input bit side_we, input logic [31:0] side_d);
    int n = 0;
    int lat;
    while (!fetch_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!fetch_ready) chk("ready_timeout", 32'd0, 32'd1);
    fetch_req = 1'b1; fetch_addr = a;
    @(negedge clk);
    fetch_req = 1'b0;
    lat = 1;
    if (side_we) begin
      prog_we = 1'b1; prog_addr = a; prog_data = side_d; prog_inj_err = 1'b0;
    end
    while (!instr_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      prog_we = 1'b0;
    end
    prog_we = 1'b0;
    chk("latency",  32'(lat), 32'd2);
    chk("hd_instr", instr, exp_i);
    chk("hd_fault", {31'b0, fetch_fault}, {31'b0, exp_f});
    chk("hd_par",   {31'b0, parity_err},  {31'b0, exp_p});
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (!fetch_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'd64);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_ready", {31'b0, fetch_ready}, 32'd0);
    chk("rst_busy",  {31'b0, prog_busy},   32'd1);
    chk("rst_par",   {31'b0, parity_err},  32'd0);
    reset = 1'b0;
    count_clear("clear_len");

    fetch(32'h10, 32'h0, 0, 0, 0, 0);
    prog(32'h4, 32'h0195_0533, 0);
    fetch(32'h4, 32'h0195_0533, 0, 0, 0, 0);
    fetch(32'h6, NOP, 1, 0, 0, 0);
    fetch(32'h100, NOP, 1, 0, 0, 0);
    fetch(32'hFFFF_FFFC, NOP, 1, 0, 0, 0);

    prog(32'hC, 32'hAAAA_5555, 0);
    fetch(32'hC, 32'hAAAA_5555, 0, 0, 1, 32'h1234_5678);
    fetch(32'hC, 32'h1234_5678, 0, 0, 0, 0);

    prog(32'h8, 32'h0000_0293, 0);
    prog(32'h9, 32'hFFFF_FFFF, 0);
    prog(32'h108, 32'hFFFF_FFFF, 0);
    fetch(32'h8, 32'h0000_0293, 0, 0, 0, 0);
    prog(32'hFC, 32'hCAFE_F00D, 0);
    fetch(32'hFC, 32'hCAFE_F00D, 0, 0, 0, 0);
    fetch(32'hFF, NOP, 1, 0, 0, 0);

`ifdef INSTR_MEM_PARITY_EN
    prog(32'h20, 32'h00A1_0113, 1);
    fetch(32'h20, 32'h00A1_0113, 0, 1, 0, 0);
    prog(32'h20, 32'h00A1_0113, 0);
    fetch(32'h20, 32'h00A1_0113, 0, 0, 0, 0);
`else
    prog(32'h20, 32'h00A1_0113, 1);
    fetch(32'h20, 32'h00A1_0113, 0, 0, 0, 0);
`endif

    // Reset partway through the clear; writes during either clear are dropped.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    prog(32'h30, 32'hDEAD_BEEF, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    prog(32'h34, 32'h1111_2222, 0);
    chk("busy_mid", {31'b0, prog_busy}, 32'd1);
    n_vec++;
    begin
      int n = 6;
      while (!fetch_ready && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (n != 64) begin
        n_bad++;
        $display("FAIL clear_restart: got %0d cycles expected 64", n);
      end
    end
    fetch(32'h30, 32'h0, 0, 0, 0, 0);
    fetch(32'h34, 32'h0, 0, 0, 0, 0);
    fetch(32'hC, 32'h0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
